// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port,
// plus a soft-clear sweep that zeroes every register one per cycle.
module regfile_write_arbiter #(
   parameter int NREQ   = 3,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   input  logic                     clear_req,
   output logic                     clear_busy,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata
);
   localparam int PW = $clog2(NREQ);
   localparam int SW = PW + 1;
   typedef enum logic {ARB, CLEAR} state_t;
   state_t              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d, gidx, idx;
   logic [SW-1:0]       sum;
   logic [ADDR_W-1:0]   count_q, count_d, rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
   logic                rf_we_q, rf_we_d, clear_busy_q, clear_busy_d, found, go;
   // Scan ptr, ptr+1, ... mod NREQ for the first valid requester.
   always_comb begin
      found = 1'b0;
      gidx = '0;
      idx = '0;
      sum = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_q} + SW'(k);
         sum = (sum >= SW'(NREQ)) ? sum - SW'(NREQ) : sum;
         idx = sum[PW-1:0];
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gidx = idx;
         end
      end
   end
   assign go = (state_q == ARB) && !clear_req && found;
   assign req_ready = (go && !reset) ? (NREQ'(1) << gidx) : '0;
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ptr_d = ptr_q;
      rf_we_d = go;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (state_q == CLEAR) begin
         rf_we_d = 1'b1;
         rf_waddr_d = count_q;
         rf_wdata_d = '0;
         count_d = count_q + 1'b1;
         state_d = (&count_q) ? ARB : CLEAR;
      end else if (clear_req) begin
         state_d = CLEAR;
         count_d = '0;
      end else if (go) begin
         rf_waddr_d = req_addr[gidx*ADDR_W +: ADDR_W];
         rf_wdata_d = req_data[gidx*DATA_W +: DATA_W];
         ptr_d = (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
      end
      clear_busy_d = (state_d == CLEAR);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB;
         count_q <= '0;
         ptr_q <= '0;
         rf_we_q <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         clear_busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ptr_q <= ptr_d;
         rf_we_q <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         clear_busy_q <= clear_busy_d;
      end
   end
   assign rf_we = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign clear_busy = clear_busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench with a round-robin reference model
// and a shadow register file fed from the observed write port.
module tb_regfile_write_arbiter;
   localparam int NREQ = 3, DW = 16, AW = 2, NREG = 4;
   logic clk = 1'b0, reset = 1'b1, clear_req = 1'b0;
   logic [NREQ-1:0] req_valid = '0, req_ready;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_data = '0;
   logic clear_busy, rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   typedef struct {int cyc; int addr; int data;} wr_t;
   wr_t q[$];
   int total = 0, bad = 0, cyc = 0, ptr = 0, clr_left = 0;
   int rf_act[NREG], rf_exp[NREG];
   logic [NREQ-1:0] hold = '0;

   regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .clear_req(clear_req),
      .clear_busy(clear_busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every observed write must match the oldest expected write for this cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
         chk("write_late", cyc, q[0].cyc);
         void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         chk("rf_we", rf_we, 1);
         if (rf_we === 1'b1) begin
            chk("rf_waddr", rf_waddr, q[0].addr);
            chk("rf_wdata", rf_wdata, q[0].data);
            rf_act[rf_waddr] = rf_wdata;
         end
         rf_exp[q[0].addr] = q[0].data;
         void'(q.pop_front());
      end else if (rf_we !== 1'b0) begin
         chk("unexpected_we", rf_we, 0);
      end
   end

   task automatic step(input logic [NREQ-1:0] v, input bit clr, input bit keep = 0);
      int g;
      logic [NREQ-1:0] er;
      for (int i = 0; i < NREQ; i++)
         if (!hold[i] && !keep) begin
            req_addr[i*AW +: AW] = AW'($urandom);
            req_data[i*DW +: DW] = DW'($urandom);
         end
      req_valid = v;
      clear_req = clr;
      @(negedge clk);
      er = '0;
      if (clr_left > 0) begin
         chk("clear_busy", clear_busy, 1);
         clr_left--;
      end else begin
         chk("clear_busy", clear_busy, 0);
         if (clr) begin
            for (int r = 0; r < NREG; r++) q.push_back('{cyc + 2 + r, r, 0});
            clr_left = NREG;
         end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
               if (g < 0 && v[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            if (g >= 0) begin
               er[g] = 1'b1;
               q.push_back('{cyc + 1, int'(req_addr[g*AW +: AW]), int'(req_data[g*DW +: DW])});
               ptr = (g + 1) % NREQ;
            end
         end
      end
      chk("req_ready", req_ready, er);
      hold = v & ~er;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '1;
      clear_req = 1'b0;
      #1;
      chk("rst_we", rf_we, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      q.delete();
      clr_left = 0;
      ptr = 0;
      hold = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic cmp_file(input string tag);
      repeat (6) step('0, 0);
      for (int r = 0; r < NREG; r++) chk({tag, "_rf"}, rf_act[r], rf_exp[r]);
   endtask

   initial begin
      for (int r = 0; r < NREG; r++) begin
         rf_act[r] = 0;
         rf_exp[r] = 0;
      end
      @(posedge clk);
      #1;
      do_reset();
      req_addr[0 +: AW] = 2'd2;
      req_data[0 +: DW] = 16'hBEEF;
      step(3'b001, 0, 1);
      cmp_file("single");
      step(3'b100, 0);
      repeat (8) step(3'b111, 0);
      cmp_file("rr");
      repeat (4) step(3'b101, 0);
      cmp_file("skip");
      step(3'b111, 1);
      repeat (6) step(3'b111, 0);
      cmp_file("clear");
      step(3'b011, 1);
      step(3'b011, 0);
      step(3'b011, 1);
      repeat (4) step(3'b011, 0);
      cmp_file("clear_ign");
      step(3'b111, 1);
      repeat (3) step(3'b111, 0);
      do_reset();
      step(3'b010, 0);
      step(3'b111, 0);
      step(3'b111, 0);
      do_reset();
      step(3'b111, 0);
      cmp_file("reset");
      repeat (300) step(NREQ'($urandom), $urandom_range(0, 19) == 0);
      cmp_file("random");
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
